// File: rtl/dma_mem_arbiter_pkg.sv
// Shared definitions for the DMA memory-port arbiter: default widths, requester
// limit and FSM state encoding.
package dma_mem_arbiter_pkg;

    localparam int DMA_AW       = 21;   // 2 MB NGS address space
    localparam int DMA_DW       = 8;
    localparam int DMA_MAX_NREQ = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/dma_mem_arbiter_rr_pick.sv
// Combinational round-robin picker: finds the first set bit of vec scanning
// upward from ptr+1 (wrapping), so the requester at ptr has lowest priority.
module dma_mem_arbiter_rr_pick
    import dma_mem_arbiter_pkg::*;
#(
    parameter  int NREQ = 4,
    localparam int PW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] vec,
    input  logic [PW-1:0]   ptr,
    output logic            any,
    output logic [NREQ-1:0] idx_oh,
    output logic [PW-1:0]   idx
);

    logic [PW-1:0] j;

    // NOTE: every variable written here gets a default first, so no path leaves one unassigned (no latch).
    always_comb begin
        any = 1'b0;
        idx = '0;
        j   = '0;
        // Walk from the farthest candidate to the nearest; the last hit wins.
        for (int k = NREQ; k >= 1; k--) begin
            j = PW'((int'(ptr) + k) % NREQ);
            if (vec[j]) begin
                any = 1'b1;
                idx = j;
            end
        end
    end

    assign idx_oh = any ? (NREQ'(1) << idx) : '0;

endmodule

// File: rtl/dma_mem_arbiter.sv
// Round-robin arbiter sharing the single DMA memory port among NREQ engines;
// one access outstanding at a time, ack/dend pulses back to each requester.
module dma_mem_arbiter
    import dma_mem_arbiter_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int AW   = DMA_AW,
    parameter int DW   = DMA_DW
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NREQ-1:0]    ena,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_wd,
    input  logic [NREQ-1:0]    req_rnw,
    output logic [NREQ-1:0]    ack,
    output logic [NREQ-1:0]    dend,
    output logic [DW-1:0]      rd_data,
    output logic               mem_req,
    output logic [AW-1:0]      mem_addr,
    output logic [DW-1:0]      mem_wd,
    output logic               mem_rnw,
    input  logic               mem_done,
    input  logic [DW-1:0]      mem_rd
);

    localparam int PW = $clog2(NREQ);

    state_t          state, state_nxt;
    logic [PW-1:0]   ptr;
    logic [PW-1:0]   gnt;
    logic            pick_any;
    logic [NREQ-1:0] pick_oh;
    logic [PW-1:0]   pick_idx;
    logic            grant;
    logic            finish;
    logic [AW-1:0]   sel_addr;
    logic [DW-1:0]   sel_wd;
    logic            sel_rnw;

    dma_mem_arbiter_rr_pick #(.NREQ(NREQ)) u_pick (
        .vec    (req & ena),
        .ptr    (ptr),
        .any    (pick_any),
        .idx_oh (pick_oh),
        .idx    (pick_idx)
    );

    // One-hot mux of the winner's access fields.
    always_comb begin
        sel_addr = '0;
        sel_wd   = '0;
        sel_rnw  = 1'b1;
        for (int i = 0; i < NREQ; i++) begin
            if (pick_oh[i]) begin
                sel_addr = req_addr[i*AW +: AW];
                sel_wd   = req_wd[i*DW +: DW];
                sel_rnw  = req_rnw[i];
            end
        end
    end

    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        grant     = 1'b0;
        finish    = 1'b0;
        case (state)
            ST_IDLE: if (pick_any) begin
                grant     = 1'b1;
                state_nxt = ST_BUSY;
            end
            ST_BUSY: if (mem_done) begin
                finish    = 1'b1;
                state_nxt = ST_DONE;
            end
            // Dead cycle so a requester dropping req right after ack is not re-granted.
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr      <= PW'(NREQ - 1);
            gnt      <= '0;
            ack      <= '0;
            dend     <= '0;
            mem_req  <= 1'b0;
            mem_rnw  <= 1'b1;
            mem_addr <= '0;
            mem_wd   <= '0;
            rd_data  <= '0;
        end else begin
            ack  <= grant ? pick_oh : '0;
            dend <= '0;
            if (grant) begin
                gnt      <= pick_idx;
                ptr      <= pick_idx;
                mem_addr <= sel_addr;
                mem_wd   <= sel_wd;
                mem_rnw  <= sel_rnw;
                mem_req  <= 1'b1;
            end
            if (finish) begin
                mem_req <= 1'b0;
                if (mem_rnw) rd_data <= mem_rd;
                // Access always completes; only the end pulse is withheld from a disabled requester.
                if (ena[gnt]) dend[gnt] <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dma_mem_arbiter.sv
// Self-checking bench for dma_mem_arbiter: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a model.
module tb_dma_mem_arbiter;

    localparam int NREQ = 4;
    localparam int AW   = 21;
    localparam int DW   = 8;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [NREQ-1:0]    ena, req, req_rnw;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_wd;
    logic [NREQ-1:0]    ack, dend;
    logic [DW-1:0]      rd_data, mem_wd, mem_rd;
    logic               mem_req, mem_rnw, mem_done;
    logic [AW-1:0]      mem_addr;

    int checks = 0;
    int errors = 0;

    dma_mem_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ena      (ena),
        .req      (req),
        .req_addr (req_addr),
        .req_wd   (req_wd),
        .req_rnw  (req_rnw),
        .ack      (ack),
        .dend     (dend),
        .rd_data  (rd_data),
        .mem_req  (mem_req),
        .mem_addr (mem_addr),
        .mem_wd   (mem_wd),
        .mem_rnw  (mem_rnw),
        .mem_done (mem_done),
        .mem_rd   (mem_rd)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Arbitration rule: among eligible requesters, the one at the smallest
    // forward distance past the previous winner.
    function automatic int rr_winner(input logic [NREQ-1:0] elig, input int last);
        int best, bestd, d;
        best  = 0;
        bestd = NREQ;
        for (int i = 0; i < NREQ; i++) begin
            d = (i - last - 1 + 2*NREQ) % NREQ;
            if (elig[i] && d < bestd) begin
                best  = i;
                bestd = d;
            end
        end
        return best;
    endfunction

    logic [NREQ-1:0] exp_ack, exp_dend;
    logic            exp_mem_req, exp_rnw;
    logic [AW-1:0]   exp_addr;
    logic [DW-1:0]   exp_wd, exp_rd;
    int              m_last;
    bit              m_inflight, m_gap;
    int              cand;

    always_comb cand = rr_winner(req & ena, m_last);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_ack     <= '0;
            exp_dend    <= '0;
            exp_mem_req <= 1'b0;
            exp_rnw     <= 1'b1;
            exp_addr    <= '0;
            exp_wd      <= '0;
            exp_rd      <= '0;
            m_last      <= NREQ - 1;
            m_inflight  <= 1'b0;
            m_gap       <= 1'b0;
        end else begin
            exp_ack  <= '0;
            exp_dend <= '0;
            if (m_gap) begin
                m_gap <= 1'b0;
            end else if (m_inflight) begin
                if (mem_done) begin
                    m_inflight  <= 1'b0;
                    m_gap       <= 1'b1;
                    exp_mem_req <= 1'b0;
                    if (exp_rnw) exp_rd <= mem_rd;
                    if (ena[m_last]) exp_dend[m_last] <= 1'b1;
                end
            end else if ((req & ena) != '0) begin
                m_last        <= cand;
                m_inflight    <= 1'b1;
                exp_mem_req   <= 1'b1;
                exp_ack[cand] <= 1'b1;
                exp_addr      <= req_addr[cand*AW +: AW];
                exp_wd        <= req_wd[cand*DW +: DW];
                exp_rnw       <= req_rnw[cand];
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            check("ack", 32'(ack), 32'(exp_ack));
            check("dend", 32'(dend), 32'(exp_dend));
            check("mem_req", 32'(mem_req), 32'(exp_mem_req));
            check("mem_rnw", 32'(mem_rnw), 32'(exp_rnw));
            check("mem_addr", 32'(mem_addr), 32'(exp_addr));
            check("mem_wd", 32'(mem_wd), 32'(exp_wd));
            check("rd_data", 32'(rd_data), 32'(exp_rd));
            check("pulse_excl", 32'(($countones(ack) <= 1) && ($countones(dend) <= 1) && !(|ack && |dend)), 1);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic rnw);
        req_addr[i*AW +: AW] = a;
        req_wd[i*DW +: DW]   = d;
        req_rnw[i]           = rnw;
        req[i]               = 1'b1;
    endtask

    task automatic wait_ack(output int who, output int lat);
        bit found;
        found = 1'b0;
        who   = -1;
        lat   = 0;
        for (int n = 1; n <= 20 && !found; n++) begin
            @(negedge clk);
            if (|ack) begin
                found = 1'b1;
                lat   = n;
                for (int j = 0; j < NREQ; j++) if (ack[j]) who = j;
            end
        end
        check("ack_seen", 32'(found), 1);
    endtask

    task automatic pulse_done(input logic [DW-1:0] d);
        mem_done = 1'b1;
        mem_rd   = d;
        @(negedge clk);
        mem_done = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int  who, lat, dly;
        bit  served;

        ena = '1; req = '0; req_rnw = '1; req_addr = '0; req_wd = '0;
        mem_done = 1'b0; mem_rd = '0;
        repeat (2) tick();
        check("rst_ack", 32'(ack), 0);
        check("rst_mem_req", 32'(mem_req), 0);
        check("rst_mem_rnw", 32'(mem_rnw), 1);
        check("rst_rd_data", 32'(rd_data), 0);
        rst_n = 1'b1;
        tick();

        // Single read from requester 0, mem_done three cycles after mem_req rises.
        set_req(0, 21'h012345, 8'h00, 1'b1);
        wait_ack(who, lat);
        check("rd_who", who, 0);
        check("rd_lat", lat, 1);
        check("rd_addr", 32'(mem_addr), 32'h012345);
        check("rd_rnw", 32'(mem_rnw), 1);
        req[0] = 1'b0;
        repeat (2) tick();
        check("rd_hold", 32'(mem_req), 1);
        tick();
        pulse_done(8'hA5);
        check("rd_dend", 32'(dend), 32'b0001);
        check("rd_data_a5", 32'(rd_data), 32'hA5);
        check("model_rd_a5", 32'(exp_rd), 32'hA5);
        tick();

        // Write from requester 1: rd_data must keep the previous read value.
        set_req(1, 21'h1FFFFF, 8'h5A, 1'b0);
        wait_ack(who, lat);
        check("wr_who", who, 1);
        check("wr_rnw", 32'(mem_rnw), 0);
        check("wr_wd", 32'(mem_wd), 32'h5A);
        check("wr_addr", 32'(mem_addr), 32'h1FFFFF);
        req[1] = 1'b0;
        pulse_done(8'h3C);
        check("wr_dend", 32'(dend), 32'b0010);
        check("wr_rd_hold", 32'(rd_data), 32'hA5);
        check("model_wr_hold", 32'(exp_rd), 32'hA5);
        tick();

        // Last grant 2, then 2 and 3 together: 3 first, then 2.
        set_req(2, 21'h000222, 8'h02, 1'b1);
        wait_ack(who, lat);
        check("g2_who", who, 2);
        req[2] = 1'b0;
        pulse_done(8'h22);
        tick();
        set_req(2, 21'h000223, 8'h02, 1'b1);
        set_req(3, 21'h000333, 8'h03, 1'b1);
        wait_ack(who, lat);
        check("pair_first", who, 3);
        req[3] = 1'b0;
        pulse_done(8'h33);
        check("pair_dend3", 32'(dend), 32'b1000);
        wait_ack(who, lat);
        check("pair_second", who, 2);
        check("pair_addr2", 32'(mem_addr), 32'h000223);
        req[2] = 1'b0;
        pulse_done(8'h44);
        tick();

        // ena[1] dropped while busy: access completes, no dend, rd_data updated.
        set_req(1, 21'h0ABCDE, 8'h00, 1'b1);
        wait_ack(who, lat);
        check("en_who", who, 1);
        req[1] = 1'b0;
        ena[1] = 1'b0;
        repeat (2) tick();
        check("en_hold", 32'(mem_req), 1);
        pulse_done(8'h77);
        check("en_no_dend", 32'(dend), 0);
        check("en_mem_req", 32'(mem_req), 0);
        check("en_rd", 32'(rd_data), 32'h77);
        tick();
        ena[1] = 1'b1;
        tick();

        // Reset pulsed mid-access, stray mem_done afterwards.
        set_req(0, 21'h055555, 8'h99, 1'b0);
        wait_ack(who, lat);
        req[0] = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("mr_ack", 32'(ack), 0);
        check("mr_dend", 32'(dend), 0);
        check("mr_mem_req", 32'(mem_req), 0);
        check("mr_rnw", 32'(mem_rnw), 1);
        check("mr_addr", 32'(mem_addr), 0);
        check("mr_wd", 32'(mem_wd), 0);
        check("mr_rd", 32'(rd_data), 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        pulse_done(8'hEE);
        check("stray_mem_req", 32'(mem_req), 0);
        check("stray_dend", 32'(dend), 0);
        check("stray_rd", 32'(rd_data), 0);
        tick();

        // All four held continuously after reset: grants 0,1,2,3,0,1.
        for (int i = 0; i < NREQ; i++) set_req(i, AW'(i*4096 + 1), DW'(i), 1'b1);
        for (int k = 0; k < 6; k++) begin
            wait_ack(who, lat);
            check("rr_order", who, k % NREQ);
            pulse_done(DW'(k + 16));
            check("rr_ack_once", 32'(ack), 0);
        end
        req = '0;
        repeat (3) tick();

        // Randomized traffic; the per-cycle compare process does the checking.
        served = 1'b0;
        dly    = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clk);
            mem_rd = DW'($urandom);
            if (mem_done) begin
                mem_done = 1'b0;
            end else if (mem_req && !served) begin
                if (dly == 0) begin
                    mem_done = 1'b1;
                    served   = 1'b1;
                end else begin
                    dly--;
                end
            end else if (!mem_req) begin
                served = 1'b0;
                dly    = int'($urandom_range(3, 0));
                if ($urandom_range(7, 0) == 0) mem_done = 1'b1;
            end
            for (int i = 0; i < NREQ; i++) begin
                if (req[i] && ack[i]) begin
                    if ($urandom_range(1, 0) == 0) req[i] = 1'b0;
                    else set_req(i, AW'($urandom), DW'($urandom), 1'($urandom));
                end else if (req[i] && $urandom_range(15, 0) == 0) begin
                    req[i] = 1'b0;
                end else if (!req[i] && $urandom_range(3, 0) == 0) begin
                    set_req(i, AW'($urandom), DW'($urandom), 1'($urandom));
                end
                if ($urandom_range(31, 0) == 0) ena[i] = ~ena[i];
            end
        end
        req      = '0;
        ena      = '1;
        mem_done = 1'b0;
        repeat (4) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
